// File: rtl/sram_pkg.sv
`default_nettype none
// ============================================================================
//  Package  : sram_pkg
//  Purpose  : Shared constants for the SRAM initialisation mux: data and
//             write-enable widths, default fill word and the sequencer
//             state encoding.
//  Revision : 1.0 - initial release
// ============================================================================
package sram_pkg;

    localparam int SRAM_DW   = 32;
    localparam int SRAM_WENW = 4;

    localparam logic [SRAM_DW-1:0] SRAM_INIT_DEFAULT = 32'h0000_0000;

    // Sequencer state encoding
    localparam logic [1:0] ST_FILL   = 2'd0;
    localparam logic [1:0] ST_VERIFY = 2'd1;
    localparam logic [1:0] ST_VCHK   = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

endpackage : sram_pkg
`default_nettype wire

// File: rtl/sram_init_mux.sv
`default_nettype none
// ============================================================================
//  Module   : sram_init_mux
//  Purpose  : Owns the single-port SRAM macro after reset (or on init_req),
//             fills every word with INIT_VALUE, optionally reads it all back
//             and checks it, then hands the macro to the AHB bridge as a
//             zero-latency combinational pass-through.
//  Config   : `SRAM_INIT_VERIFY_EN enables the read-back VERIFY/VCHK pass
//             and the sticky init_err flag; undefined gives FILL->DONE.
//  Revision : 1.0 - initial release
// ============================================================================
module sram_init_mux
    import sram_pkg::*;
#(
    parameter int                  AW         = 11,
    parameter logic [SRAM_DW-1:0]  INIT_VALUE = SRAM_INIT_DEFAULT
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  init_req,

    input  logic                  BR_CS,
    input  logic [SRAM_WENW-1:0]  BR_WEN,
    input  logic [AW-3:0]         BR_ADDR,
    input  logic [SRAM_DW-1:0]    BR_WDATA,
    output logic [SRAM_DW-1:0]    BR_RDATA,

    output logic                  SRAM_CS,
    output logic [SRAM_WENW-1:0]  SRAM_WEN,
    output logic [AW-3:0]         SRAM_ADDR,
    output logic [SRAM_DW-1:0]    SRAM_WDATA,
    input  logic [SRAM_DW-1:0]    SRAM_RDATA,

    output logic                  init_busy,
    output logic                  init_done,
    output logic                  acc_drop,
    output logic                  init_err
);

    localparam int              WAW         = AW - 2;
    localparam logic [WAW-1:0]  c_ADDR_LAST = '1;
    localparam logic [WAW-1:0]  c_ADDR_ONE  = {{(WAW-1){1'b0}}, 1'b1};

    logic [1:0]     state_q, state_d;
    logic [WAW-1:0] addr_q,  addr_d;
    logic           acc_drop_q;

    logic           w_done;
    logic           w_addr_last;
    logic           w_restart;

    assign w_done      = (state_q == ST_DONE);
    assign w_addr_last = (addr_q == c_ADDR_LAST);
    assign w_restart   = w_done && init_req;

    // State and address register; reset always restarts the fill at word 0
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q <= ST_FILL;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    // Next-state logic; the counter wraps to 0 on its own after the last word
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        case (state_q)
            ST_FILL: begin
                addr_d = addr_q + c_ADDR_ONE;
                if (w_addr_last) begin
`ifdef SRAM_INIT_VERIFY_EN
                    state_d = ST_VERIFY;
`else
                    state_d = ST_DONE;
`endif
                end
            end
`ifdef SRAM_INIT_VERIFY_EN
            ST_VERIFY: begin
                addr_d = addr_q + c_ADDR_ONE;
                if (w_addr_last) begin
                    state_d = ST_VCHK;
                end
            end
            ST_VCHK: begin
                state_d = ST_DONE;
            end
`endif
            ST_DONE: begin
                if (init_req) begin
                    state_d = ST_FILL;
                    addr_d  = '0;
                end
            end
            default: begin
                state_d = ST_FILL;
                addr_d  = '0;
            end
        endcase
    end

    // Output mux: sequencer drives the macro while busy, bridge owns it in DONE
    always_comb begin
        SRAM_CS    = 1'b0;
        SRAM_WEN   = '0;
        SRAM_ADDR  = addr_q;
        SRAM_WDATA = INIT_VALUE;
        init_busy  = 1'b1;
        init_done  = 1'b0;
        case (state_q)
            ST_FILL: begin
                SRAM_CS  = 1'b1;
                SRAM_WEN = '1;
            end
`ifdef SRAM_INIT_VERIFY_EN
            ST_VERIFY: begin
                SRAM_CS = 1'b1;
            end
`endif
            ST_DONE: begin
                SRAM_CS    = BR_CS;
                SRAM_WEN   = BR_WEN;
                SRAM_ADDR  = BR_ADDR;
                SRAM_WDATA = BR_WDATA;
                init_busy  = 1'b0;
                init_done  = 1'b1;
            end
            default: begin
                SRAM_CS = 1'b0;
            end
        endcase
    end

    assign BR_RDATA = SRAM_RDATA;

    // Sticky record of bridge accesses that arrived while the macro was busy
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            acc_drop_q <= 1'b0;
        end else if (w_restart) begin
            acc_drop_q <= 1'b0;
        end else if (!w_done && BR_CS) begin
            acc_drop_q <= 1'b1;
        end
    end

    assign acc_drop = acc_drop_q;

`ifdef SRAM_INIT_VERIFY_EN
    logic rd_pend_q;
    logic init_err_q;

    // Read-back check: data for the read issued last cycle is compared now
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            rd_pend_q  <= 1'b0;
            init_err_q <= 1'b0;
        end else begin
            rd_pend_q <= (state_q == ST_VERIFY);
            if (w_restart) begin
                init_err_q <= 1'b0;
            end else if (rd_pend_q && (SRAM_RDATA != INIT_VALUE)) begin
                init_err_q <= 1'b1;
            end
        end
    end

    assign init_err = init_err_q;
`else
    assign init_err = 1'b0;
`endif

endmodule : sram_init_mux
`default_nettype wire
